wide_add_sequencer: RTL and testbench
=====================================

Name: wide_add_sequencer

Overview:
Multi-cycle wide adder controller. It performs a WORDS*N-bit addition by sequencing a single shared N-bit carry_skip_adder instance over WORDS consecutive chunks, LSB chunk first, chaining the carry through a register. It has a valid/ready operand interface and a valid/ready result interface, and sits between the operand-issue logic and result consumers wherever full-width adders are too costly.

Parameters:
N, 8, width of the internal carry_skip_adder (chunk width); must be a multiple of BLOCK_SIZE.
BLOCK_SIZE, 4, skip-block size passed to the internal carry_skip_adder.
WORDS, 4, number of chunks; total operand width W = N*WORDS; WORDS >= 1.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request.
in_ready  output  1  block can accept operands (high only in IDLE).
a  input  N*WORDS  operand A.
b  input  N*WORDS  operand B.
cin  input  1  carry into chunk 0.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
sum  output  N*WORDS  result register.
cout  output  1  carry out of the top chunk.
ovf  output  1  two's-complement signed overflow of the full W-bit add.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; a_reg, b_reg, sum, chunk index idx, carry register, cout and ovf all 0; in_ready=1; out_valid=0; busy=0. Reset is effective immediately, including mid-RUN or in DONE. Any in-flight operation is discarded and no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. When in_valid=1 at a rising edge (accept): a_reg<=a, b_reg<=b, carry<=cin, idx<=0, go to RUN. sum, cout and ovf keep their previous values until overwritten.
- RUN: in_ready=0, in_valid is ignored. Each cycle the adder computes a_reg[idx*N +: N] + b_reg[idx*N +: N] + carry, combinationally.
  - At the edge: sum[idx*N +: N] <= adder sum; carry <= adder cout; idx <= idx+1.
  - When idx==WORDS-1 at the edge: cout <= adder cout; ovf <= (a_reg[W-1]==b_reg[W-1]) && (adder sum MSB != a_reg[W-1]); go to DONE.
- DONE: out_valid=1; sum, cout and ovf are stable. When out_ready=1 at an edge, go to IDLE; out_valid drops the following cycle. out_valid stays asserted indefinitely while out_ready=0 (backpressure), with outputs held.
- Latency: accept edge at cycle T puts the block in RUN. out_valid is first high in the cycle after edge T+WORDS. Minimum issue interval is WORDS+2 cycles (one cycle each for IDLE and DONE). No overlap of operations.
- sum is only meaningful while out_valid=1. During RUN it holds a mix of new low chunks and old high chunks.
- Arithmetic: the result must equal (a + b + cin) mod 2^W, with cout as bit W of the result. Arithmetic is unsigned, except that ovf is the signed interpretation.
- WORDS=1: RUN lasts exactly one cycle.
- out_ready asserted outside DONE has no effect. in_valid asserted outside IDLE has no effect; the operand is not captured.
- busy = (state != IDLE).

Test Plan:
- W=32, a=0xFFFFFFFF, b=0x00000001, cin=0 -> carry ripples across all 4 chunks; sum=0x00000000, cout=1, ovf=0; out_valid high exactly 4 cycles after the accept edge.
- a=0x7FFFFFFF, b=0x00000000, cin=1 -> sum=0x80000000, cout=0, ovf=1. Then a=0x80000000, b=0x80000000, cin=0 -> sum=0, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid, sum, cout and ovf stable; in_ready=0 throughout, and in_valid pulses during this time are not captured. out_ready=1 -> IDLE next cycle with in_ready=1.
- Reset mid-RUN: accept a=0x12345678, b=0x11111111, drop rst_n in RUN cycle 2 -> all outputs immediately at reset values. Release, then issue a=0x00000005, b=0x00000003 -> sum=0x00000008, with no result from the aborted operation.
- Back-to-back: in_valid and out_ready held high with 3 random operand pairs -> each result matches a+b+cin, and accepts are spaced exactly 6 cycles apart.
- Random: 1000 random a, b, cin with random out_ready stalls, checked against a 33-bit reference model (sum, cout, ovf).

Source files
------------

// File: rtl/wide_add_sequencer.sv
// Multi-cycle W = N*WORDS bit adder that reuses one N-bit carry-skip adder
// over WORDS chunks (LSB first) and chains the carry through a register.

module carry_skip_adder #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  localparam int NB = N / BLOCK_SIZE;

  logic [NB-1:0] blk_p;
  logic [N-1:0]  s;
  logic          c_out;

  for (genvar gi = 0; gi < NB; gi++) begin : g_prop
    assign blk_p[gi] = &(a_i[gi*BLOCK_SIZE +: BLOCK_SIZE] ^ b_i[gi*BLOCK_SIZE +: BLOCK_SIZE]);
  end

  // Ripple inside each block; a fully propagating block passes its carry-in straight through.
  always_comb begin
    logic c;
    logic bc;
    s     = '0;
    c     = cin_i;
    bc    = cin_i;
    for (int k = 0; k < NB; k++) begin
      bc = c;
      for (int j = 0; j < BLOCK_SIZE; j++) begin
        s[k*BLOCK_SIZE+j] = a_i[k*BLOCK_SIZE+j] ^ b_i[k*BLOCK_SIZE+j] ^ c;
        c = (a_i[k*BLOCK_SIZE+j] & b_i[k*BLOCK_SIZE+j]) |
            ((a_i[k*BLOCK_SIZE+j] ^ b_i[k*BLOCK_SIZE+j]) & c);
      end
      c = blk_p[k] ? bc : c;
    end
    c_out = c;
  end

  assign sum_o  = s;
  assign cout_o = c_out;
endmodule

module wide_add_sequencer #(
  parameter int N          = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int WORDS      = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WORDS-1:0] a,
  input  logic [N*WORDS-1:0] b,
  input  logic               cin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WORDS-1:0] sum,
  output logic               cout,
  output logic               ovf,
  output logic               busy
);
  localparam int W    = N * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic [IDXW-1:0] idx_q;
  logic            carry_q, cout_q, ovf_q;

  logic [N-1:0]    a_words [WORDS];
  logic [N-1:0]    b_words [WORDS];
  logic [N-1:0]    a_chunk, b_chunk, add_sum;
  logic            add_cout;
  logic            last_chunk;

  for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
    assign a_words[gi] = a_q[gi*N +: N];
    assign b_words[gi] = b_q[gi*N +: N];
  end

  assign a_chunk    = a_words[idx_q];
  assign b_chunk    = b_words[idx_q];
  assign last_chunk = (idx_q == IDXW'(WORDS - 1));

  carry_skip_adder #(
    .N          (N),
    .BLOCK_SIZE (BLOCK_SIZE)
  ) u_adder (
    .a_i    (a_chunk),
    .b_i    (b_chunk),
    .cin_i  (carry_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        if (last_chunk) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_q == IDXW'(k)) sum_q[k*N +: N] <= add_sum;
          end
          carry_q <= add_cout;
          idx_q   <= idx_q + 1'b1;
          // Signed overflow: equal operand signs but a differing result sign.
          if (last_chunk) begin
            cout_q <= add_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (add_sum[N-1] != a_q[W-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer (N=8, WORDS=4, W=32).

module tb_wide_add_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int unsigned cyc_cnt = 0;
  logic [W+1:0] exp_q [$];

  wide_add_sequencer #(.N(8), .BLOCK_SIZE(4), .WORDS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {sum[31:0], cout, ovf} from 33-bit unsigned add
  function automatic logic [W+1:0] ref_fn(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    logic [W:0] s;
    logic       o;
    s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
    o = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
    return {s[W-1:0], s[W], o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic [W+1:0] ev);
    int t = 0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    cin = cv;
    while (in_ready !== 1'b1 && t < 50) begin
      step();
      t++;
    end
    step();
    in_valid = 1'b0;
    exp_q.push_back(ev);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 50) begin
      step();
      cyc++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    total_cnt++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, {W{1'b0}}, 2'b00})
      $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, need 1 0 0 0 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) step();
    total_cnt++;
    if ({in_ready, out_valid, busy} !== 3'b100)
      $display("FAIL reset_release: got rdy=%b vld=%b busy=%b, need 1 0 0", in_ready, out_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_ripple();
    int cyc;
    logic [W+1:0] ev;
    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, {32'h0000_0000, 1'b1, 1'b0});
    wait_valid(cyc);
    total_cnt++;
    if (cyc !== 4) $display("FAIL ripple_latency: got %0d cycles, need 4", cyc);
    else pass_cnt++;
    ev = exp_q.pop_front();
    total_cnt++;
    if ({sum, cout, ovf} !== ev)
      $display("FAIL ripple_result: got %h/%b/%b, need %h/%b/%b", sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
    else pass_cnt++;
    $display("txn ripple: sum=%h cout=%b ovf=%b", sum, cout, ovf);
    release_result();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL ripple_return_idle: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int cyc;
    logic [W+1:0] ev;
    accept(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, {32'h8000_0000, 1'b0, 1'b1});
    wait_valid(cyc);
    ev = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== ev)
      $display("FAIL ovf_pos: got vld=%b %h/%b/%b, need 1 %h/%b/%b", out_valid, sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
    else pass_cnt++;
    $display("txn ovf_pos: sum=%h cout=%b ovf=%b", sum, cout, ovf);
    release_result();
    accept(32'h8000_0000, 32'h8000_0000, 1'b0, {32'h0000_0000, 1'b1, 1'b1});
    wait_valid(cyc);
    ev = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== ev)
      $display("FAIL ovf_neg: got vld=%b %h/%b/%b, need 1 %h/%b/%b", out_valid, sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
    else pass_cnt++;
    $display("txn ovf_neg: sum=%h cout=%b ovf=%b", sum, cout, ovf);
    release_result();
  endtask

  task automatic test_backpressure();
    int cyc;
    logic [W+1:0] ev;
    accept(32'h0F0F_0F0F, 32'h0101_0101, 1'b1, {32'h1010_1011, 1'b0, 1'b0});
    wait_valid(cyc);
    ev = exp_q[0];
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = $urandom;
      b = $urandom;
      total_cnt++;
      if ({out_valid, in_ready, sum, cout, ovf} !== {2'b10, ev})
        $display("FAIL backpressure_hold[%0d]: got vld=%b rdy=%b %h/%b/%b, need 1 0 %h/%b/%b",
                 i, out_valid, in_ready, sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
      else pass_cnt++;
      step();
    end
    in_valid = 1'b0;
    void'(exp_q.pop_front());
    $display("txn backpressure: sum=%h cout=%b ovf=%b", sum, cout, ovf);
    release_result();
    total_cnt++;
    if ({in_ready, out_valid} !== 2'b10)
      $display("FAIL backpressure_release: got rdy=%b vld=%b, need 1 0", in_ready, out_valid);
    else pass_cnt++;
    repeat (3) step();
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL backpressure_no_capture: got busy=%b, need 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int stray = 0;
    logic [W+1:0] ev;
    accept(32'h1234_5678, 32'h1111_1111, 1'b0, ref_fn(32'h1234_5678, 32'h1111_1111, 1'b0));
    step();
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    total_cnt++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, {W{1'b0}}, 2'b00})
      $display("FAIL midrun_reset: got rdy=%b vld=%b busy=%b sum=%h cout=%b ovf=%b, need 1 0 0 0 0 0",
               in_ready, out_valid, busy, sum, cout, ovf);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid !== 1'b0) stray++;
    end
    total_cnt++;
    if (stray !== 0) $display("FAIL midrun_no_result: got %0d out_valid cycles, need 0", stray);
    else pass_cnt++;
    accept(32'h0000_0005, 32'h0000_0003, 1'b0, {32'h0000_0008, 1'b0, 1'b0});
    wait_valid(cyc);
    ev = exp_q.pop_front();
    total_cnt++;
    if (out_valid !== 1'b1 || {sum, cout, ovf} !== ev)
      $display("FAIL midrun_next_op: got vld=%b %h/%b/%b, need 1 %h/%b/%b", out_valid, sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
    else pass_cnt++;
    $display("txn after_reset: sum=%h cout=%b ovf=%b", sum, cout, ovf);
    release_result();
  endtask

  task automatic test_back_to_back();
    int n_acc = 0;
    int guard = 0;
    int t_acc [3];
    bit pending;
    logic [W+1:0] ev;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = $urandom;
    b = $urandom;
    cin = $urandom_range(0, 1);
    while ((n_acc < 3 || exp_q.size() > 0) && guard < 100) begin
      pending = in_valid && in_ready;
      if (out_valid === 1'b1) begin
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_result: got unexpected result %h, need none", sum);
        else begin
          ev = exp_q.pop_front();
          if ({sum, cout, ovf} !== ev)
            $display("FAIL b2b_result: got %h/%b/%b, need %h/%b/%b", sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
          else pass_cnt++;
        end
        $display("txn b2b: sum=%h cout=%b ovf=%b", sum, cout, ovf);
      end
      if (pending) exp_q.push_back(ref_fn(a, b, cin));
      step();
      guard++;
      if (pending) begin
        t_acc[n_acc] = int'(cyc_cnt);
        n_acc++;
        if (n_acc < 3) begin
          a = $urandom;
          b = $urandom;
          cin = $urandom_range(0, 1);
        end else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total_cnt++;
    if (n_acc !== 3 || exp_q.size() != 0)
      $display("FAIL b2b_complete: got %0d accepts, %0d pending, need 3 and 0", n_acc, exp_q.size());
    else pass_cnt++;
    if (n_acc == 3) begin
      for (int i = 1; i < 3; i++) begin
        total_cnt++;
        if (t_acc[i] - t_acc[i-1] !== 6)
          $display("FAIL b2b_spacing[%0d]: got %0d cycles, need 6", i, t_acc[i] - t_acc[i-1]);
        else pass_cnt++;
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int cyc;
    logic [W-1:0] ra, rb;
    logic rc;
    logic [W+1:0] ev;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) ra = 32'hFFFF_FFFF;
      if ($urandom_range(0, 9) == 0) rb = ~ra;
      accept(ra, rb, rc, ref_fn(ra, rb, rc));
      wait_valid(cyc);
      repeat ($urandom_range(0, 3)) step();
      total_cnt++;
      if (exp_q.size() == 0) $display("FAIL random_result[%0d]: got no expected entry", i);
      else begin
        ev = exp_q.pop_front();
        if (out_valid !== 1'b1 || {sum, cout, ovf} !== ev)
          $display("FAIL random_result[%0d]: got vld=%b %h/%b/%b, need 1 %h/%b/%b",
                   i, out_valid, sum, cout, ovf, ev[W+1:2], ev[1], ev[0]);
        else pass_cnt++;
      end
      $display("txn random %0d: a=%h b=%h cin=%b sum=%h cout=%b ovf=%b", i, ra, rb, rc, sum, cout, ovf);
      release_result();
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  initial begin
    test_reset();
    test_ripple();
    test_overflow();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
